// File: rtl/bg_sar_ctrl_pkg.sv
// Shared types and constants for the bandgap SAR trim sequencer.
package bg_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PWRUP,
    ZERO,
    SMP_P,
    NOV1,
    SMP_N,
    NOV2,
    CMP,
    DECIDE
  } state_t;

  // Active-low DAC output routing codes
  localparam logic [3:0] OUTSEL_OFF = 4'b1111;
  localparam logic [3:0] OUTSEL_CAL = 4'b1110;
  localparam logic [3:0] OUTSEL_RUN = 4'b1101;

  // One-hot mask for a SAR bit position
  function automatic logic [7:0] bit_mask(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/bg_sar_ctrl_if.sv
// Control/readback bundle between the host logic, the sequencer and the bandgap core.
interface bg_sar_ctrl_if;

  logic       enable;
  logic       start;
  logic [7:0] cfg_coarse;
  logic       cfg_swap;
  logic       cfg_stable;
  logic       CMPO;

  logic       pwrup;
  logic [7:0] idacFine;
  logic [7:0] idacCoarse;
  logic [3:0] idacOutSelect_n;
  logic [7:0] diodeSelect;
  logic       resStableSelect;
  logic       resPtatEnable_n;
  logic [1:0] c1;
  logic [1:0] c2;
  logic       cmpZeroOffset;
  logic       cmpSwapInput;
  logic       busy;
  logic       done;
  logic [7:0] code;

  // Host side: requests runs and models the analog core
  modport master (
    output enable, start, cfg_coarse, cfg_swap, cfg_stable, CMPO,
    input  pwrup, idacFine, idacCoarse, idacOutSelect_n, diodeSelect,
           resStableSelect, resPtatEnable_n, c1, c2, cmpZeroOffset,
           cmpSwapInput, busy, done, code
  );

  // Sequencer side
  modport slave (
    input  enable, start, cfg_coarse, cfg_swap, cfg_stable, CMPO,
    output pwrup, idacFine, idacCoarse, idacOutSelect_n, diodeSelect,
           resStableSelect, resPtatEnable_n, c1, c2, cmpZeroOffset,
           cmpSwapInput, busy, done, code
  );

endinterface

// File: rtl/bg_sar_ctrl_sync2.sv
// Generic two-flop synchronizer for bringing asynchronous signals into clk.
module bg_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first stage a full cycle to resolve
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bg_sar_ctrl.sv
// Bandgap trim sequencer: power-up, offset zero, two-phase sampling and an
// 8-bit successive-approximation search on idacFine, then IOUT enable.
// CMP_CYCLES must be at least 3 so the synchronized comparator has settled.
module bg_sar_ctrl
  import bg_ctrl_pkg::*;
#(
  parameter int         PWRUP_CYCLES = 16,
  parameter int         ZERO_CYCLES  = 4,
  parameter int         PHASE_CYCLES = 4,
  parameter int         CMP_CYCLES   = 4,
  parameter logic [7:0] DIODE_P      = 8'h01,
  parameter logic [7:0] DIODE_N      = 8'hFF
) (
  input logic         clk,
  input logic         reset,
  bg_sar_ctrl_if.slave bus
);

  // Counter reload values: a state lasts (reload + 1) cycles
  localparam logic [7:0] PWRUP_LEN = 8'(PWRUP_CYCLES - 1);
  localparam logic [7:0] ZERO_LEN  = 8'(ZERO_CYCLES - 1);
  localparam logic [7:0] PHASE_LEN = 8'(PHASE_CYCLES - 1);
  localparam logic [7:0] CMP_LEN   = 8'(CMP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] trial_q, trial_d;
  logic [7:0] result_q, result_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic [7:0] coarse_q, coarse_d;
  logic       swap_q, swap_d;
  logic       stable_q, stable_d;
  logic       done_d;

  logic       pwrup_q, pwrup_d;
  logic [7:0] fine_q, fine_d;
  logic [7:0] coarse_o_q, coarse_o_d;
  logic [3:0] outsel_q, outsel_d;
  logic [7:0] diode_q, diode_d;
  logic       stable_o_q, stable_o_d;
  logic       ptat_n_q, ptat_n_d;
  logic [1:0] c1_q, c1_d;
  logic [1:0] c2_q, c2_d;
  logic       zero_q, zero_d;
  logic       swap_o_q, swap_o_d;
  logic       busy_q, busy_d;
  logic       done_q;

  logic       cmpo_sync;
  logic       cmp_eff;

  bg_sync2 #(.WIDTH(1)) u_cmpo_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.CMPO),
    .q     (cmpo_sync)
  );

  // Undo the comparator input swap so the decision polarity is fixed
  assign cmp_eff = cmpo_sync ^ swap_q;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      trial_q    <= '0;
      result_q   <= '0;
      bit_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      coarse_q   <= '0;
      swap_q     <= 1'b0;
      stable_q   <= 1'b0;
      pwrup_q    <= 1'b0;
      fine_q     <= '0;
      coarse_o_q <= '0;
      outsel_q   <= OUTSEL_OFF;
      diode_q    <= '0;
      stable_o_q <= 1'b0;
      ptat_n_q   <= 1'b1;
      c1_q       <= '0;
      c2_q       <= '0;
      zero_q     <= 1'b0;
      swap_o_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trial_q    <= trial_d;
      result_q   <= result_d;
      bit_q      <= bit_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      coarse_q   <= coarse_d;
      swap_q     <= swap_d;
      stable_q   <= stable_d;
      pwrup_q    <= pwrup_d;
      fine_q     <= fine_d;
      coarse_o_q <= coarse_o_d;
      outsel_q   <= outsel_d;
      diode_q    <= diode_d;
      stable_o_q <= stable_o_d;
      ptat_n_q   <= ptat_n_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      zero_q     <= zero_d;
      swap_o_q   <= swap_o_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state, counter reloads and SAR bookkeeping; enable low aborts to IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    trial_d  = trial_q;
    result_d = result_q;
    bit_d    = bit_q;
    code_d   = code_q;
    valid_d  = valid_q;
    coarse_d = coarse_q;
    swap_d   = swap_q;
    stable_d = stable_q;
    done_d   = 1'b0;

    if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;

    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d  = PWRUP;
            cnt_d    = PWRUP_LEN;
            coarse_d = bus.cfg_coarse;
            swap_d   = bus.cfg_swap;
            stable_d = bus.cfg_stable;
            trial_d  = 8'h80;
            result_d = 8'h00;
            bit_d    = 3'd7;
          end
        end
        PWRUP:  if (cnt_q == 8'd0) begin state_d = ZERO;   cnt_d = ZERO_LEN;  end
        ZERO:   if (cnt_q == 8'd0) begin state_d = SMP_P;  cnt_d = PHASE_LEN; end
        SMP_P:  if (cnt_q == 8'd0) begin state_d = NOV1;   cnt_d = 8'd0;      end
        NOV1:   begin state_d = SMP_N; cnt_d = PHASE_LEN; end
        SMP_N:  if (cnt_q == 8'd0) begin state_d = NOV2;   cnt_d = 8'd0;      end
        NOV2:   begin state_d = CMP; cnt_d = CMP_LEN; end
        CMP:    if (cnt_q == 8'd0) begin state_d = DECIDE; cnt_d = 8'd0;      end
        DECIDE: begin
          result_d = cmp_eff ? (result_q | bit_mask(bit_q))
                             : (result_q & ~bit_mask(bit_q));
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            trial_d = result_d | bit_mask(bit_q - 3'd1);
            state_d = SMP_P;
            cnt_d   = PHASE_LEN;
          end else begin
            code_d  = result_d;
            valid_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so registered outputs line up with it
  always_comb begin
    pwrup_d    = 1'b0;
    fine_d     = '0;
    coarse_o_d = '0;
    outsel_d   = OUTSEL_OFF;
    diode_d    = '0;
    stable_o_d = 1'b0;
    ptat_n_d   = 1'b1;
    c1_d       = '0;
    c2_d       = '0;
    zero_d     = 1'b0;
    swap_o_d   = 1'b0;
    busy_d     = 1'b0;

    if (state_d == IDLE) begin
      if (valid_d) begin
        pwrup_d    = 1'b1;
        ptat_n_d   = 1'b0;
        outsel_d   = OUTSEL_RUN;
        fine_d     = code_d;
        coarse_o_d = coarse_d;
        stable_o_d = stable_d;
      end
    end else begin
      pwrup_d    = 1'b1;
      ptat_n_d   = 1'b0;
      outsel_d   = OUTSEL_CAL;
      fine_d     = trial_d;
      coarse_o_d = coarse_d;
      stable_o_d = stable_d;
      swap_o_d   = swap_d;
      busy_d     = 1'b1;
      case (state_d)
        ZERO:  zero_d = 1'b1;
        SMP_P: begin diode_d = DIODE_P; c1_d = 2'b11; end
        SMP_N: begin diode_d = DIODE_N; c2_d = 2'b11; end
        default: ;
      endcase
    end
  end

  assign bus.pwrup           = pwrup_q;
  assign bus.idacFine        = fine_q;
  assign bus.idacCoarse      = coarse_o_q;
  assign bus.idacOutSelect_n = outsel_q;
  assign bus.diodeSelect     = diode_q;
  assign bus.resStableSelect = stable_o_q;
  assign bus.resPtatEnable_n = ptat_n_q;
  assign bus.c1              = c1_q;
  assign bus.c2              = c2_q;
  assign bus.cmpZeroOffset   = zero_q;
  assign bus.cmpSwapInput    = swap_o_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.code            = code_q;

endmodule
